shift_queue: RTL

SHIFT_QUEUE -- requirements
Module: shift_queue

---
 rtl/shift_queue_if.sv | 26 ++
 rtl/shift_queue.sv | 76 +++++++
 2 files changed

// File: rtl/shift_queue_if.sv
// Handshake bundle for shift_queue: a command channel (operand + right-shift
// amount) flowing in, and a result channel flowing out, both valid/ready.
// Ports: in_valid/in_ready/in_data/in_amt (command), out_valid/out_ready/out_data (result).
// Modports: master = producer/consumer side, slave = the queue itself.
interface shift_queue_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AMT_W-1:0] in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/shift_queue.sv
// Purpose: DEPTH-entry FIFO of shift commands; the head is presented as
// operand >> amount (logical, zero-filled), zero when the queue is empty.
// Latency: a push into an empty queue is visible right after that edge; no bypass.
// Backpressure: in_ready depends only on occupancy (never on out_ready), so a
// full queue refuses a push even on an edge that also pops.
// Ports: clk, rst (synchronous, active-high), q (shift_queue_if.slave),
// count (occupancy, present only when SHIFT_QUEUE_COUNT_EN is defined).
// Parameters: WIDTH must equal 2**AMT_W; DEPTH is a power of two >= 2.
module shift_queue #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef SHIFT_QUEUE_COUNT_EN
   shift_queue_if.slave             q,
   output logic [$clog2(DEPTH):0]   count
`else
   shift_queue_if.slave             q
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [AMT_W-1:0] amt_mem  [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   occ;

   logic do_push;
   logic do_pop;

   assign q.in_ready  = (occ != OCC_FULL);
   assign q.out_valid = (occ != '0);

   assign do_push = q.in_valid  && q.in_ready;
   assign do_pop  = q.out_valid && q.out_ready;

   // Shift is applied on the way out so storage only holds raw operands; the
   // result is forced to zero when nothing is queued.
   assign q.out_data = q.out_valid ? (data_mem[rd_ptr] >> amt_mem[rd_ptr]) : '0;

   // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage is not reset; the occupancy counter alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         data_mem[wr_ptr] <= q.in_data;
         amt_mem[wr_ptr]  <= q.in_amt;
      end
   end

`ifdef SHIFT_QUEUE_COUNT_EN
   assign count = occ;
`endif

endmodule
